// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the LEGv8 commit trace buffer.
// The optional per-entry timestamp is enabled with the TRACE_TIMESTAMP_EN macro.
package cpu_trace_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int TS_W       = 32;
    localparam int TRC_PC_W    = 64;
    localparam int TRC_INSTR_W = 32;

    typedef enum logic [1:0] {
        TRC_IDLE    = 2'd0,
        TRC_ARMED   = 2'd1,
        TRC_CAPTURE = 2'd2,
        TRC_DONE    = 2'd3
    } trc_state_t;

    typedef struct packed {
        logic [TRC_PC_W-1:0]    pc;
        logic [TRC_INSTR_W-1:0] instr;
`ifdef TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]        ts;
`endif
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// DEPTH x W flop array: one synchronous write port, one asynchronous read port.
// Data flops carry no reset; the top masks the read data while nothing is valid.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular commit trace buffer: capture until a PC trigger plus a post window, then drain oldest-first.
// Build with TRACE_TIMESTAMP_EN to store a free-running cycle stamp per entry and expose rd_ts.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int PC_W     = 64,
    parameter int INSTR_W  = 32,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    commit_valid,
    input  logic [PC_W-1:0]         commit_pc,
    input  logic [INSTR_W-1:0]      commit_instr,
    input  logic                    arm,
    input  logic                    trig_en,
    input  logic [PC_W-1:0]         trig_pc,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [PC_W-1:0]         rd_pc,
    output logic [INSTR_W-1:0]      rd_instr,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]         rd_ts,
`endif
    output logic [$clog2(DEPTH):0]  level,
    output logic [DROP_CNT_W-1:0]   drop_cnt,
    output logic [1:0]              state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = PC_W + INSTR_W + TS_W;
`else
    localparam int ENTRY_W = PC_W + INSTR_W;
`endif
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [AW-1:0] POST_LD  = AW'(POST_CNT);

    trc_state_t        st, st_nxt;
    logic [AW-1:0]     wr_ptr, rd_ptr, post_cnt;
    logic [ENTRY_W-1:0] wdata, rdata;
    logic              trig_hit, wr_en, pop;

    // Handshake: a pop happens on a cycle where rd_valid & rd_ready are both high and arm is low.
    assign trig_hit = commit_valid && (!trig_en || commit_pc == trig_pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= TRC_IDLE;
        else       st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (arm) begin
            st_nxt = TRC_ARMED;
        end else begin
            case (st)
                TRC_ARMED:   if (trig_hit) st_nxt = (POST_CNT == 0) ? TRC_DONE : TRC_CAPTURE;
                TRC_CAPTURE: if (commit_valid && post_cnt == AW'(1)) st_nxt = TRC_DONE;
                TRC_DONE:    if (pop && level == LW'(1)) st_nxt = TRC_IDLE;
                default:     st_nxt = st;
            endcase
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        rd_valid = 1'b0;
        pop      = 1'b0;
        if (st == TRC_ARMED || st == TRC_CAPTURE) wr_en = commit_valid && !arm;
        if (st == TRC_DONE) begin
            rd_valid = (level != '0);
            pop      = (level != '0) && rd_ready && !arm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
            post_cnt <= '0;
        end else if (arm) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
            post_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                // Full buffer: overwrite the oldest entry instead of growing.
                if (level == FULL_LVL) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    if (drop_cnt != {DROP_CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
                end else begin
                    level <= level + LW'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                level  <= level - LW'(1);
            end
            if (st == TRC_ARMED && trig_hit)            post_cnt <= POST_LD;
            else if (st == TRC_CAPTURE && commit_valid) post_cnt <= post_cnt - AW'(1);
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + 1'b1;
    end

    assign wdata = {commit_pc, commit_instr, ts_cnt};
    assign rd_ts = rd_valid ? rdata[TS_W-1:0] : '0;
`else
    assign wdata = {commit_pc, commit_instr};
`endif

    trace_ram #(.DEPTH(DEPTH), .W(ENTRY_W), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign rd_pc    = rd_valid ? rdata[ENTRY_W-1 -: PC_W] : '0;
    assign rd_instr = rd_valid ? rdata[ENTRY_W-PC_W-1 -: INSTR_W] : '0;
    assign state    = st;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: queue-based reference model, per-cycle compare, directed and random phases.
module tb_cpu_trace_buffer;
    import cpu_trace_pkg::*;

    localparam int PC_W = 64, INSTR_W = 32, DEPTH = 16, POST_CNT = 8;

    logic clk = 1'b0;
    logic reset, commit_valid, arm, trig_en, rd_ready;
    logic [PC_W-1:0] commit_pc, trig_pc;
    logic [INSTR_W-1:0] commit_instr;
    logic rd_valid;
    logic [PC_W-1:0] rd_pc;
    logic [INSTR_W-1:0] rd_instr;
    logic [4:0] level;
    logic [15:0] drop_cnt;
    logic [1:0] state;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] rd_ts;
    logic [31:0] got_ts[$];
`endif

    cpu_trace_buffer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .POST_CNT(POST_CNT)) dut (
        .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_instr(commit_instr), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts(rd_ts),
`endif
        .level(level), .drop_cnt(drop_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;

    // Reference model: captured entries as a queue of {pc, instr, ts}, oldest at index 0.
    logic [127:0] m_q[$];
    int m_state, m_drop, m_post;
    logic [31:0] m_ts;
    logic [63:0] got_q[$];

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_state = 0;
        m_drop = 0;
        m_post = 0;
        m_ts = '0;
    endfunction

    function automatic void model_step();
        if (arm) begin
            m_q.delete();
            m_drop = 0;
            m_state = 1;
        end else if ((m_state == 1 || m_state == 2) && commit_valid) begin
            m_q.push_back({commit_pc, commit_instr, m_ts});
            if (m_q.size() > DEPTH) begin
                void'(m_q.pop_front());
                if (m_drop < 65535) m_drop++;
            end
            if (m_state == 1) begin
                if (!trig_en || commit_pc == trig_pc) begin
                    m_post = POST_CNT;
                    m_state = (POST_CNT == 0) ? 3 : 2;
                end
            end else begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end
        end else if (m_state == 3 && rd_ready && m_q.size() > 0) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_state = 0;
        end
        m_ts = m_ts + 1;
    endfunction

    always @(negedge clk) begin
        logic [127:0] head;
        if (!reset) begin
            head = (m_state == 3 && m_q.size() > 0) ? m_q[0] : '0;
            check("rd_valid", rd_valid, (m_state == 3 && m_q.size() != 0));
            check("level", level, m_q.size());
            check("drop_cnt", drop_cnt, m_drop);
            check("state", state, m_state);
            check("rd_pc", rd_pc, head[127:64]);
            check("rd_instr", rd_instr, head[63:32]);
`ifdef TRACE_TIMESTAMP_EN
            check("rd_ts", rd_ts, head[31:0]);
`endif
        end
    end

    task automatic tick();
        if (rd_valid && rd_ready && !arm && !reset) begin
            got_q.push_back(rd_pc);
`ifdef TRACE_TIMESTAMP_EN
            got_ts.push_back(rd_ts);
`endif
        end
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic commit(input logic [63:0] pc);
        commit_valid = 1'b1;
        commit_pc = pc;
        commit_instr = $urandom;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic drain_all(input bit toggle);
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (m_state == 3 && n < 80) begin
            rd_ready = toggle ? ~n[0] : 1'b1;
            tick();
            n++;
        end
        rd_ready = 1'b0;
        check("drain_bound", (m_state == 3), 1'b0);
    endtask

    initial begin
        logic [63:0] pc;
        int found, n;
        commit_valid = 0; arm = 0; trig_en = 0; rd_ready = 0;
        commit_pc = '0; commit_instr = '0; trig_pc = '0;
        do_reset();
        check("reset_state", state, 2'd0);
        check("reset_level", level, 5'd0);
        check("reset_valid", rd_valid, 1'b0);

        // Trigger on first commit, then an 8-commit post window.
        do_arm();
        check("armed", state, 2'd1);
        commit(64'h100); commit(64'h104); commit(64'h108);
        check("t1_state", state, 2'd2);
        check("t1_level", level, 5'd3);
        for (int i = 0; i < 6; i++) commit(64'h10C + 4 * i);
        check("t1_done", state, 2'd3);
        check("t1_level9", level, 5'd9);
        got_q.delete();
        drain_all(0);
        check("t1_count", got_q.size(), 9);
        check("t1_first", got_q[0], 64'h100);

        // PC-match trigger with wrap and drops; commits separated by random idle gaps.
        trig_en = 1; trig_pc = 64'h40;
        do_arm();
        pc = 0; n = 0;
        while (m_state != 3 && n < 200) begin
            if ($urandom_range(0, 2) == 0) tick();
            else begin commit(pc); pc += 4; end
            n++;
        end
        check("t2_last_pc", pc - 4, 64'h60);
        check("t2_drop", drop_cnt, 16'd9);
        check("t2_level", level, 5'd16);

        // Drain with rd_ready alternating high/low.
        got_q.delete();
        rd_ready = 1;
        for (int i = 0; i < 32; i++) begin
            rd_ready = (i % 2 == 0);
            tick();
        end
        rd_ready = 0;
        check("t3_idle", state, 2'd0);
        check("t3_count", got_q.size(), 16);
        check("t3_first", got_q[0], 64'h24);
        check("t3_last", got_q[15], 64'h60);

        // Re-arm during CAPTURE beats a same-cycle commit.
        trig_en = 0;
        do_arm();
        for (int i = 0; i < 5; i++) commit(64'h200 + 4 * i);
        check("t4_level5", level, 5'd5);
        arm = 1; commit(64'hDEAD); arm = 0;
        check("t4_armed", state, 2'd1);
        check("t4_level0", level, 5'd0);
        check("t4_drop0", drop_cnt, 16'd0);
        for (int i = 0; i < 9; i++) commit(64'h300 + 4 * i);
        got_q.delete();
        drain_all(0);
        found = 0;
        foreach (got_q[i]) if (got_q[i] == 64'hDEAD) found++;
        check("t4_absent", found, 0);

        // Asynchronous reset mid-drain.
        do_arm();
        for (int i = 0; i < 9; i++) commit(64'h400 + 4 * i);
        rd_ready = 1; tick(); tick(); rd_ready = 0;
        reset = 1; model_reset(); #1;
        check("t5_valid", rd_valid, 1'b0);
        check("t5_state", state, 2'd0);
        check("t5_level", level, 5'd0);
        reset = 0;
        do_arm();
        commit(64'h500); commit(64'h504); commit(64'h508);
        check("t5_restart", level, 5'd3);

`ifdef TRACE_TIMESTAMP_EN
        // Commits at counter values 10, 11 and 15 after reset.
        do_reset();
        do_arm();
        for (int i = 1; i < 10; i++) tick();
        commit(64'h600); commit(64'h604);
        tick(); tick(); tick();
        commit(64'h608);
        for (int i = 0; i < 6; i++) commit(64'h700 + 4 * i);
        got_ts.delete();
        drain_all(0);
        check("t6_ts0", got_ts[0], 32'd10);
        check("t6_ts1", got_ts[1], 32'd11);
        check("t6_ts2", got_ts[2], 32'd15);
`endif

        // Random traffic: rare arms and resets, a small PC pool so matches occur.
        for (int i = 0; i < 1500; i++) begin
            arm = ($urandom_range(0, 39) == 0);
            if (arm) trig_en = $urandom_range(0, 1);
            trig_pc = 64'h40;
            commit_valid = $urandom_range(0, 1);
            commit_pc = 64'(4 * $urandom_range(0, 31));
            commit_instr = $urandom;
            rd_ready = $urandom_range(0, 1);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1;
                tick();
                reset = 0;
            end else begin
                tick();
            end
        end
        arm = 0; commit_valid = 0; rd_ready = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
